// File: rtl/uart_tx.sv
// uart_tx: MSB-first 8N1-style serialiser with a one-word holding register,
// bit-timed by an oversampling tick strobe; back-to-back frames have no idle gap.
module uart_tx #(
    parameter int N          = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tick_i,
    input  logic [N-1:0] data_i,
    input  logic         tx_valid_i,
    output logic         tx_ready_o,
    output logic         tx_o,
    output logic         tx_busy_o,
    output logic         tx_done_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [N-1:0]  hold;
    logic [N-1:0]  shift;
    logic          hold_valid;
    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] bit_idx;
    logic          bit_end;

    assign tx_ready_o = ~hold_valid;
    assign tx_busy_o  = state != IDLE;
    assign bit_end    = tick_cnt == TW'(OVERSAMPLE - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            tx_o       <= 1'b1;
            tx_done_o  <= 1'b0;
        end else begin
            tx_done_o <= 1'b0;
            // accept and drain are mutually exclusive: one needs hold empty, the other full
            if (tx_valid_i && !hold_valid) begin
                hold       <= data_i;
                hold_valid <= 1'b1;
            end
            if (tick_i) begin
                if (state == IDLE) begin
                    if (hold_valid) begin
                        shift      <= hold;
                        hold_valid <= 1'b0;
                        tx_o       <= 1'b0;
                        tick_cnt   <= '0;
                        state      <= START;
                    end
                end else if (!bit_end) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    tick_cnt <= '0;
                    case (state)
                        START: begin
                            tx_o    <= shift[N-1];
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                        DATA: begin
                            if (bit_idx == BW'(N - 1)) begin
                                tx_o  <= 1'b1;
                                state <= STOP;
                            end else begin
                                shift   <= shift << 1;
                                tx_o    <= shift[N-2];
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                        default: begin
                            tx_done_o <= 1'b1;
                            if (hold_valid) begin
                                shift      <= hold;
                                hold_valid <= 1'b0;
                                tx_o       <= 1'b0;
                                state      <= START;
                            end else begin
                                tx_o  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: per-cycle check of uart_tx against a tick-counting frame model,
// plus table-driven frame vectors and directed corner-case sequences.
module tb_uart_tx;
    localparam int N     = 8;
    localparam int OS    = 16;
    localparam int FRAME = (N + 2) * OS;

    logic         clk = 1'b0;
    logic         rst, tick, valid;
    logic [N-1:0] data;
    logic         ready, tx, busy, done;

    always #5 clk = ~clk;

    uart_tx #(.N(N), .OVERSAMPLE(OS)) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .data_i(data), .tx_valid_i(valid),
        .tx_ready_o(ready), .tx_o(tx), .tx_busy_o(busy), .tx_done_o(done)
    );

    int n_chk = 0, n_fail = 0, cyc_no = 0;
    int tk_per = 1, phase = 0;

    // model: a frame is a sequence of ticks; the line value is a function of ticks elapsed
    bit           m_busy, m_held, m_done;
    int           m_ticks;
    logic [N-1:0] m_cur, m_hw;
    int           n_acc = 0, n_done = 0;

    typedef struct {
        logic [N-1:0] data;
        int           per;
        logic [9:0]   bits;
        int           len;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, got, exp);
        end
    endtask

    function automatic logic exp_tx();
        int k = m_ticks / OS;
        if (!m_busy) return 1'b1;
        if (k == 0) return 1'b0;
        if (k <= N) return m_cur[N-k];
        return 1'b1;
    endfunction

    task automatic step(input bit r, input bit v, input logic [N-1:0] d);
        bit tk, acc;
        tk = (tk_per == 0) ? ($urandom_range(0, 7) != 0) : (phase % tk_per == 0);
        phase++;
        rst = r; tick = tk; valid = v; data = d;
        @(posedge clk);
        #1;
        cyc_no++;
        if (r) begin
            m_busy = 0; m_held = 0; m_ticks = 0; m_done = 0;
        end else begin
            m_done = 0;
            acc = v && !m_held;
            if (tk) begin
                if (m_busy) begin
                    m_ticks++;
                    if (m_ticks == FRAME) begin
                        m_done = 1;
                        if (m_held) begin m_cur = m_hw; m_held = 0; m_ticks = 0; end
                        else m_busy = 0;
                    end
                end else if (m_held) begin
                    m_busy = 1; m_cur = m_hw; m_held = 0; m_ticks = 0;
                end
            end
            if (acc) begin m_held = 1; m_hw = d; n_acc++; end
        end
        if (done === 1'b1) n_done++;
        check("tx/busy/ready/done", {28'd0, tx, busy, ready, done},
              {28'd0, exp_tx(), m_busy, !m_held, m_done});
    endtask

    task automatic do_reset();
        step(1, 0, '0);
        step(1, 0, '0);
        phase = 0;
    endtask

    initial begin
        int c, len, a0, d0, zeros;
        logic [9:0] got;
        rst = 1; tick = 0; valid = 0; data = '0;
        vecs[0] = '{8'hA5, 4, 10'b0101001011, 640};
        vecs[1] = '{8'h3C, 1, 10'b0001111001, 160};
        vecs[2] = '{8'h81, 2, 10'b0100000011, 320};
        vecs[3] = '{8'h00, 3, 10'b0000000001, 480};
        vecs[4] = '{8'hFF, 1, 10'b0111111111, 160};

        do_reset();
        check("reset_outputs", {28'd0, tx, busy, ready, done}, 32'b1010);

        foreach (vecs[i]) begin
            do_reset();
            tk_per = vecs[i].per;
            step(0, 1, vecs[i].data);
            c = -1; len = -1; got = '1;
            for (int j = 0; j < FRAME * vecs[i].per + 60; j++) begin
                step(0, 0, '0);
                if (c >= 0) c++;
                else if (tx === 1'b0) c = 0;
                if (c >= 0 && c % (OS * vecs[i].per) == OS * vecs[i].per / 2 && c / (OS * vecs[i].per) < 10)
                    got[9 - c / (OS * vecs[i].per)] = tx;
                if (done === 1'b1 && len < 0) len = c;
            end
            check("frame_bits", {22'd0, got}, {22'd0, vecs[i].bits});
            check("frame_len", len, vecs[i].len);
        end

        // back-to-back: second word queued during data phase starts on the done edge
        do_reset();
        tk_per = 2;
        step(0, 1, 8'h3C);
        for (int j = 0; j < 4 * FRAME && !(m_busy && m_ticks >= 2 * OS); j++) step(0, 0, '0);
        step(0, 1, 8'hF0);
        c = 0;
        for (int j = 0; j < 4 * FRAME && done !== 1'b1; j++) begin step(0, 0, '0); c++; end
        check("b2b_done_seen", {31'd0, done}, 1);
        check("b2b_start_on_done", {30'd0, tx, busy}, 2'b01);
        for (int j = 0; j < 2 * FRAME + 10; j++) step(0, 0, '0);

        // handshake hold-off: valid held high with changing data
        do_reset();
        tk_per = 1;
        a0 = n_acc; d0 = n_done;
        for (int j = 0; j < 3 * FRAME; j++) step(0, 1, N'($urandom));
        for (int j = 0; j < 3 * FRAME; j++) step(0, 0, '0);
        check("holdoff_frames", n_done - d0, n_acc - a0);

        // idle ticks
        do_reset();
        d0 = n_done;
        for (int j = 0; j < 100; j++) step(0, 0, '0);
        check("idle_no_done", n_done - d0, 0);
        check("idle_line", {30'd0, tx, busy}, 2'b10);

        // reset during D4 of 0x81 with a second word held
        do_reset();
        step(0, 1, 8'h81);
        step(0, 1, 8'h5A);
        step(0, 1, 8'h5A);
        for (int j = 0; j < 2 * FRAME && !(m_busy && m_ticks >= 4 * OS + 8); j++) step(0, 0, '0);
        check("mid_frame_held", {31'd0, ready}, 0);
        step(1, 0, '0);
        check("rst_mid_frame", {29'd0, tx, ready, busy}, 3'b110);
        d0 = n_done; zeros = 0;
        for (int j = 0; j < 2 * FRAME; j++) begin step(0, 0, '0); if (tx === 1'b0) zeros++; end
        check("rst_no_stale_done", n_done - d0, 0);
        check("rst_no_stale_frame", zeros, 0);

        // randomized traffic with irregular ticks
        do_reset();
        tk_per = 0;
        a0 = n_acc; d0 = n_done;
        for (int j = 0; j < 24000; j++) step(0, $urandom_range(0, 3) != 0, N'($urandom));
        tk_per = 1;
        for (int j = 0; j < 2 * FRAME + 10; j++) step(0, 0, '0);
        check("random_frames", n_done - d0, n_acc - a0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
